// File: rtl/bin2bcd_pkg.sv
// Shared constants, state encoding and helpers for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  localparam int unsigned DIGITS_DEF = 4;
  localparam int unsigned BIN_W_DEF  = 14;
  localparam int unsigned MAX_VAL    = 9999;
  localparam int unsigned CNT_W_DEF  = $clog2(BIN_W_DEF + 1);

  // Display patterns for an out-of-range input: "EEEE" by default, "9999" when saturating
  localparam logic [4*DIGITS_DEF-1:0] OVF_PATTERN = 16'hEEEE;
  localparam logic [4*DIGITS_DEF-1:0] SAT_PATTERN = 16'h9999;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Largest value representable in the given number of decimal digits
  function automatic int unsigned max_val(input int unsigned digits);
    int unsigned r;
    r = 1;
    for (int unsigned i = 0; i < digits; i++) r = r * 10;
    return r - 1;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Request/result bundle between the converter and its user (master drives start/bin_in).
interface bin2bcd_seq_if
  import bin2bcd_pkg::*;
#(
  parameter int unsigned BIN_W  = BIN_W_DEF,
  parameter int unsigned DIGITS = DIGITS_DEF
) ();

  logic                  start;
  logic [BIN_W-1:0]      bin_in;
  logic                  ready;
  logic                  busy;
  logic                  done;
  logic                  overflow;
  logic [4*DIGITS-1:0]   bcd_out;

  modport master (
    output start, bin_in,
    input  ready, busy, done, overflow, bcd_out
  );

  modport slave (
    input  start, bin_in,
    output ready, busy, done, overflow, bcd_out
  );

endinterface

// File: rtl/bin2bcd_seq_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD nibble that is 5 or more.
module bcd_digit_adj (
  input  logic [3:0] d,
  output logic [3:0] adj_c
);

  // Pre-shift correction so the nibble carries correctly into the next digit
  always_comb begin
    adj_c = d;
    if (d >= 4'd5) adj_c = d + 4'd3;
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), constant BIN_W+1 edge latency.
// Result is held between conversions so the downstream display never sees partial values.
// Build option: define BIN2BCD_SATURATE_EN to show all 9s instead of all Es on overflow.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int unsigned BIN_W  = BIN_W_DEF,
  parameter int unsigned DIGITS = DIGITS_DEF
) (
  input logic          clk,
  input logic          rst_n,
  bin2bcd_seq_if.slave bus
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);
  localparam int unsigned MAX_V = max_val(DIGITS);

  localparam logic [1:0] ST_IDLE  = 2'(IDLE);
  localparam logic [1:0] ST_SHIFT = 2'(SHIFT);
  localparam logic [1:0] ST_DONE  = 2'(DONE);

`ifdef BIN2BCD_SATURATE_EN
  localparam logic [BCD_W-1:0] OVF_RESULT = {DIGITS{SAT_PATTERN[3:0]}};
`else
  localparam logic [BCD_W-1:0] OVF_RESULT = {DIGITS{OVF_PATTERN[3:0]}};
`endif

  logic [1:0]             state_q, state_d;
  logic [BIN_W-1:0]       bin_q;
  logic [BCD_W-1:0]       scr_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   ovf_pend_q;
  logic [BCD_W-1:0]       adj_c;
  logic [BCD_W+BIN_W-1:0] shl_c;
  logic                   ready_d, busy_d, done_d;

  // Per-digit add-3 correction on the scratch register
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d     (scr_q[4*g +: 4]),
      .adj_c (adj_c[4*g +: 4])
    );
  end

  // One double-dabble step: corrected scratch and binary shifted left as one vector
  assign shl_c = {adj_c, bin_q} << 1;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state and next values of the registered handshake outputs
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.start) state_d = ST_SHIFT;
      ST_SHIFT: if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_IDLE);
    busy_d  = !ready_d;
    done_d  = (state_q == ST_DONE);
  end

  // Registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.ready <= 1'b1;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
    end else begin
      bus.ready <= ready_d;
      bus.busy  <= busy_d;
      bus.done  <= done_d;
    end
  end

  // Conversion datapath: capture on accept, shift while in SHIFT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q      <= '0;
      scr_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
    end else if (state_q == ST_IDLE && bus.start) begin
      bin_q      <= bus.bin_in;
      scr_q      <= '0;
      cnt_q      <= CNT_W'(BIN_W);
      ovf_pend_q <= (32'(bus.bin_in) > MAX_V);
    end else if (state_q == ST_SHIFT) begin
      scr_q <= shl_c[BCD_W+BIN_W-1:BIN_W];
      bin_q <= shl_c[BIN_W-1:0];
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // Result publish: bcd_out and overflow change only on the done edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.bcd_out  <= '0;
      bus.overflow <= 1'b0;
    end else if (state_q == ST_DONE) begin
      bus.bcd_out  <= ovf_pend_q ? OVF_RESULT : scr_q;
      bus.overflow <= ovf_pend_q;
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: cycle-level reference model plus directed literal checks.
module tb_bin2bcd_seq;

  localparam int unsigned BIN_W  = 14;
  localparam int unsigned DIGITS = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bin2bcd_seq_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

  bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors   = 0;
  int checks   = 0;
  int done_cnt = 0;

  // Reference model state: edges since acceptance (0 = idle) and the published result
  int          m_cnt  = 0;
  int unsigned m_val  = 0;
  logic        m_done = 1'b0;
  logic        m_ovf  = 1'b0;
  logic [15:0] m_bcd  = 16'h0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Decimal digits by plain arithmetic; out-of-range gives the overflow pattern
  function automatic logic [15:0] ref_conv(input int unsigned v);
    logic [15:0] r;
    int unsigned t;
    if (v > 9999) begin
`ifdef BIN2BCD_SATURATE_EN
      return 16'h9999;
`else
      return 16'hEEEE;
`endif
    end
    t = v;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Compare every cycle against the model, then advance the model for the coming edge
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_cnt  = 0;
        m_done = 1'b0;
        m_ovf  = 1'b0;
        m_bcd  = 16'h0;
      end
      check("done",     16'(bus.done),     16'(m_done));
      check("busy",     16'(bus.busy),     16'(m_cnt != 0));
      check("ready",    16'(bus.ready),    16'(m_cnt == 0));
      check("overflow", 16'(bus.overflow), 16'(m_ovf));
      check("bcd_out",  bus.bcd_out,       m_bcd);
      if (bus.done === 1'b1) done_cnt++;
      if (rst_n) begin
        if (m_cnt == 0) begin
          m_done = 1'b0;
          if (bus.start) begin
            m_cnt = 1;
            m_val = 32'(bus.bin_in);
          end
        end else if (m_cnt == int'(BIN_W) + 1) begin
          m_cnt  = 0;
          m_done = 1'b1;
          m_bcd  = ref_conv(m_val);
          m_ovf  = (m_val > 9999);
        end else begin
          m_cnt++;
          m_done = 1'b0;
        end
      end
    end
  end

  task automatic accept(input logic [13:0] v);
    @(posedge clk); #1;
    bus.start  = 1'b1;
    bus.bin_in = v;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    check("accept_busy", 16'(bus.busy), 16'd1);
  endtask

  // Wait for a done pulse; n = negedges seen before it (bounded)
  task automatic wait_done(output int n);
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      if (bus.done === 1'b1) break;
      n++;
    end
    if (n >= 40) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done within 40 cycles expected done at %0t", $time);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish by 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int d0;
    logic [15:0] ovf_exp;
`ifdef BIN2BCD_SATURATE_EN
    ovf_exp = 16'h9999;
`else
    ovf_exp = 16'hEEEE;
`endif
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.bin_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 16'(bus.ready), 16'd1);
    check("rst_busy",  16'(bus.busy),  16'd0);
    check("rst_bcd",   bus.bcd_out,    16'h0000);
    rst_n = 1'b1;

    // Basic conversion and latency
    accept(14'd1234);
    wait_done(n);
    check("lat_1234", 16'(n), 16'd15);
    check("bcd_1234", bus.bcd_out, 16'h1234);
    check("ovf_1234", 16'(bus.overflow), 16'd0);

    // Back-to-back: start held high through the done cycle
    @(posedge clk); #1;
    bus.start = 1'b1; bus.bin_in = 14'd0;
    @(posedge clk); #1;
    bus.bin_in = 14'd9999;
    wait_done(n);
    check("bcd_0", bus.bcd_out, 16'h0000);
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("b2b_accept", 16'(bus.busy), 16'd1);
    wait_done(n);
    check("b2b_gap", 16'(n + 1), 16'd16);
    check("bcd_9999", bus.bcd_out, 16'h9999);

    // Overflow, then recovery
    accept(14'd10000);
    wait_done(n);
    check("lat_ovf", 16'(n), 16'd15);
    check("bcd_ovf", bus.bcd_out, ovf_exp);
    check("ovf_set", 16'(bus.overflow), 16'd1);
    accept(14'd42);
    wait_done(n);
    check("bcd_42", bus.bcd_out, 16'h0042);
    check("ovf_clr", 16'(bus.overflow), 16'd0);

    // Start while busy is ignored
    accept(14'd1234);
    repeat (4) @(posedge clk);
    #1; bus.start = 1'b1; bus.bin_in = 14'd5678;
    @(posedge clk); #1; bus.start = 1'b0;
    wait_done(n);
    check("ign_bcd", bus.bcd_out, 16'h1234);
    @(posedge clk);
    d0 = done_cnt;
    repeat (20) @(negedge clk);
    check("ign_no_extra_done", 16'(done_cnt - d0), 16'd0);

    // Reset mid-conversion aborts with no done
    accept(14'd4321);
    repeat (6) @(posedge clk);
    #1; rst_n = 1'b0;
    #1;
    check("abort_busy",  16'(bus.busy),  16'd0);
    check("abort_ready", 16'(bus.ready), 16'd1);
    check("abort_bcd",   bus.bcd_out,    16'h0000);
    d0 = done_cnt;
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b1;
    repeat (20) @(posedge clk);
    check("abort_no_done", 16'(done_cnt - d0), 16'd0);
    accept(14'd4321);
    wait_done(n);
    check("lat_4321", 16'(n), 16'd15);
    check("bcd_4321", bus.bcd_out, 16'h4321);

    // bin_in wiggles during the conversion; output holds until done
    accept(14'd807);
    n = 0;
    while (n < 40) begin
      @(posedge clk); #1;
      bus.bin_in = 14'($urandom);
      @(negedge clk);
      if (bus.done === 1'b1) break;
      check("hold_bcd", bus.bcd_out, 16'h4321);
      n++;
    end
    check("lat_807", 16'(n), 16'd14);
    check("bcd_807", bus.bcd_out, 16'h0807);

    // Random traffic: random start/bin_in every cycle, occasional reset
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      rst_n      = ($urandom_range(0, 199) != 0);
      bus.start  = ($urandom_range(0, 2) == 0);
      bus.bin_in = ($urandom_range(0, 1) == 0) ? 14'($urandom_range(0, 9999))
                                                : 14'($urandom_range(0, 16383));
    end
    @(posedge clk); #1;
    rst_n     = 1'b1;
    bus.start = 1'b0;
    repeat (20) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
